// File: rtl/matmul_pkg.sv
// Shared types and helpers for the output-stationary systolic matmul engine.
// Optional overflow detection is enabled with `define MATMUL_OVF_DETECT_EN.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Array dimension: one row of operands spans a result/bias bus word.
  function automatic int calc_n(int bus_w, int data_w);
    return bus_w / data_w;
  endfunction

  // Compute length: last PE (N-1,N-1) consumes k=N-1 at step 3N-3.
  function automatic int calc_t(int n);
    return 3 * n - 2;
  endfunction

  // Element index within a row-major flattened N x N matrix.
  function automatic int elem_idx(int row, int col, int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/matmul_systolic_engine_mac_pe.sv
// One processing element of the systolic array: forwards A right and B
// down through a register each, and accumulates signed products modulo
// 2^bus_width. With MATMUL_OVF_DETECT_EN a sticky signed-overflow bit is kept.
module mac_pe #(
  parameter int data_width = 16,
  parameter int bus_width  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  en,
  input  logic [bus_width-1:0]  bias_in,
  input  logic [data_width-1:0] a_in,
  input  logic [data_width-1:0] b_in,
  output logic [data_width-1:0] a_out,
  output logic [data_width-1:0] b_out,
  output logic [bus_width-1:0]  acc
`ifdef MATMUL_OVF_DETECT_EN
  ,
  output logic                  ovf
`endif
);

  localparam int EXT = bus_width - data_width;

  logic signed [bus_width-1:0] a_ext, b_ext, prod;
  logic        [bus_width-1:0] sum;

  // Operands are sign-extended first so the truncated product equals the
  // exact signed product whenever bus_width >= 2*data_width.
  assign a_ext = {{EXT{a_in[data_width-1]}}, a_in};
  assign b_ext = {{EXT{b_in[data_width-1]}}, b_in};
  assign prod  = a_ext * b_ext;
  assign sum   = acc + prod;

  // Pass-through registers and accumulator; load seeds bias and clears the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (load) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= bias_in;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= sum;
    end
  end

`ifdef MATMUL_OVF_DETECT_EN
  logic step_ovf;

  // Signed overflow: both addends share a sign that the sum does not.
  assign step_ovf = (acc[bus_width-1] == prod[bus_width-1]) &&
                    (sum[bus_width-1] != acc[bus_width-1]);

  // Sticky overflow bit, cleared whenever a new computation is loaded.
  always_ff @(posedge clk) begin
    if (reset || load) ovf <= 1'b0;
    else if (en)       ovf <= ovf | step_ovf;
  end
`endif

endmodule

// File: rtl/matmul_systolic_engine.sv
// Output-stationary N x N systolic matmul: C = A*B (+ bias), N = bus_width/data_width.
// Row i of A and column j of B are skewed by i / j cycles so PE(i,j) meets
// a(i,k) and b(k,j) at step i+j+k. c_mat is written in the DONE cycle.
// Optional macro MATMUL_OVF_DETECT_EN adds the ovf_flags output.
module matmul_systolic_engine
  import matmul_pkg::*;
#(
  parameter  int data_width = 16,
  parameter  int bus_width  = 32,
  localparam int N          = calc_n(bus_width, data_width),
  localparam int DIMW       = $clog2(N) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N*N*data_width-1:0] a_mat,
  input  logic [N*N*data_width-1:0] b_mat,
  input  logic [N*N*bus_width-1:0]  bias_mat,
  input  logic                      bias_en,
  input  logic [DIMW-1:0]           dim_m,
  input  logic [DIMW-1:0]           dim_k,
  input  logic [DIMW-1:0]           dim_n,
  output logic                      busy,
  output logic                      finsh_calc,
  output logic [N*N*bus_width-1:0]  c_mat,
  output logic                      dim_err
`ifdef MATMUL_OVF_DETECT_EN
  ,
  output logic [N*N-1:0]            ovf_flags
`endif
);

  localparam int T  = calc_t(N);
  localparam int TW = (T > 1) ? $clog2(T) : 1;

  state_t                    state_q, state_d;
  logic [TW-1:0]             t_q;
  logic [N*N*data_width-1:0] a_lat, b_lat;
  logic [DIMW-1:0]           dm_q, dk_q, dn_q;
  logic                      dims_ok, accept, reject, run;

  logic [data_width-1:0] a_src  [N];
  logic [data_width-1:0] b_src  [N];
  logic [data_width-1:0] a_link [N][N];
  logic [data_width-1:0] b_link [N][N];
  logic [data_width-1:0] a_unused [N];
  logic [data_width-1:0] b_unused [N];
  logic [bus_width-1:0]  acc    [N][N];
`ifdef MATMUL_OVF_DETECT_EN
  logic                  pe_ovf [N][N];
`endif

  assign dims_ok = (dim_m != '0) && (int'(dim_m) <= N) &&
                   (dim_k != '0) && (int'(dim_k) <= N) &&
                   (dim_n != '0) && (int'(dim_n) <= N);
  assign run = (state_q == COMPUTE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status decode; start is only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    reject     = 1'b0;
    busy       = 1'b0;
    finsh_calc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            accept  = 1'b1;
            state_d = COMPUTE;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (t_q == TW'(T - 1)) state_d = DONE;
      end
      DONE: begin
        finsh_calc = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Step counter, restarted on every accepted request.
  always_ff @(posedge clk) begin
    if (reset || accept) t_q <= '0;
    else if (run)        t_q <= t_q + 1'b1;
  end

  // Operand/dimension capture so inputs may change after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_lat <= '0;
      b_lat <= '0;
      dm_q  <= '0;
      dk_q  <= '0;
      dn_q  <= '0;
    end else if (accept) begin
      a_lat <= a_mat;
      b_lat <= b_mat;
      dm_q  <= dim_m;
      dk_q  <= dim_k;
      dn_q  <= dim_n;
    end
  end

  // Unskewed edge streams: at step t row r offers a(r,t), column r offers
  // b(t,r); inactive rows/columns and k beyond dim_k inject zero.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      a_src[r] = '0;
      b_src[r] = '0;
    end
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        if ((int'(t_q) == k) && (k < int'(dk_q))) begin
          if (r < int'(dm_q)) a_src[r] = a_lat[elem_idx(r, k, N)*data_width +: data_width];
          if (r < int'(dn_q)) b_src[r] = b_lat[elem_idx(k, r, N)*data_width +: data_width];
        end
      end
    end
  end

  // Skew delay lines: row i / column i is delayed by i cycles.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_link[0][0] = a_src[0];
      assign b_link[0][0] = b_src[0];
    end else begin : g_dly
      logic [data_width-1:0] a_sh [i];
      logic [data_width-1:0] b_sh [i];

      // Shift during COMPUTE, cleared when a new job is accepted.
      always_ff @(posedge clk) begin
        if (reset || accept) begin
          for (int s = 0; s < i; s++) begin
            a_sh[s] <= '0;
            b_sh[s] <= '0;
          end
        end else if (run) begin
          a_sh[0] <= a_src[i];
          b_sh[0] <= b_src[i];
          for (int s = 1; s < i; s++) begin
            a_sh[s] <= a_sh[s-1];
            b_sh[s] <= b_sh[s-1];
          end
        end
      end

      assign a_link[i][0] = a_sh[i-1];
      assign b_link[0][i] = b_sh[i-1];
    end
  end

  // PE grid; A flows right, B flows down, last column/row outputs dropped.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [data_width-1:0] a_o, b_o;
      logic [bus_width-1:0]  bias_in;

      assign bias_in = bias_en ? bias_mat[elem_idx(i, j, N)*bus_width +: bus_width] : '0;

      mac_pe #(
        .data_width (data_width),
        .bus_width  (bus_width)
      ) u_pe (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .en      (run),
        .bias_in (bias_in),
        .a_in    (a_link[i][j]),
        .b_in    (b_link[i][j]),
        .a_out   (a_o),
        .b_out   (b_o),
        .acc     (acc[i][j])
`ifdef MATMUL_OVF_DETECT_EN
        ,
        .ovf     (pe_ovf[i][j])
`endif
      );

      if (j < N - 1) begin : g_a_pass
        assign a_link[i][j+1] = a_o;
      end else begin : g_a_edge
        assign a_unused[i] = a_o;
      end
      if (i < N - 1) begin : g_b_pass
        assign b_link[i+1][j] = b_o;
      end else begin : g_b_edge
        assign b_unused[j] = b_o;
      end
    end
  end

  // Result capture in DONE; elements outside the active m x n window read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_mat <= '0;
    end else if (state_q == DONE) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c_mat[elem_idx(i, j, N)*bus_width +: bus_width] <=
            ((i < int'(dm_q)) && (j < int'(dn_q))) ? acc[i][j] : '0;
    end
  end

  // Rejected start (bad dims) gives a one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (reset) dim_err <= 1'b0;
    else       dim_err <= reject;
  end

`ifdef MATMUL_OVF_DETECT_EN
  // Overflow flags follow c_mat and clear when a new job is accepted.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      ovf_flags <= '0;
    end else if (state_q == DONE) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          ovf_flags[elem_idx(i, j, N)] <= pe_ovf[i][j];
    end
  end
`endif

endmodule

// File: tb/tb_matmul_systolic_engine.sv
// Scoreboard bench for matmul_systolic_engine (default parameters, N=2).
// Expected results come from a plain matrix-arithmetic model.
module tb_matmul_systolic_engine;

  localparam int DW = 16;
  localparam int BW = 32;
  localparam int N  = 2;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            bias_en = 1'b0;
  logic [N*N*DW-1:0] a_mat = '0, b_mat = '0;
  logic [N*N*BW-1:0] bias_mat = '0;
  logic [1:0]      dim_m = '0, dim_k = '0, dim_n = '0;
  logic            busy, finsh_calc, dim_err;
  logic [N*N*BW-1:0] c_mat;
`ifdef MATMUL_OVF_DETECT_EN
  logic [N*N-1:0]  ovf_flags;
`endif

  matmul_systolic_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a_mat      (a_mat),
    .b_mat      (b_mat),
    .bias_mat   (bias_mat),
    .bias_en    (bias_en),
    .dim_m      (dim_m),
    .dim_k      (dim_k),
    .dim_n      (dim_n),
    .busy       (busy),
    .finsh_calc (finsh_calc),
    .c_mat      (c_mat),
    .dim_err    (dim_err)
`ifdef MATMUL_OVF_DETECT_EN
    ,
    .ovf_flags  (ovf_flags)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N*N*BW-1:0] c;
    logic [N*N-1:0]    ovf;
    int                fin_cyc;
  } exp_t;

  exp_t exp_q[$];
  logic [N*N*BW-1:0] last_c = '0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [N*N*BW-1:0] act,
                         input logic [N*N*BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: C(i,j) = bias(i,j) + sum_k a(i,k)*b(k,j) in the active window,
  // wrapped to 32 bits; overflow if any running sum leaves the int32 range.
  function automatic exp_t model(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b,
                                 input logic [N*N*BW-1:0] bias, input logic be,
                                 input int m, input int k, input int n);
    exp_t e;
    longint acc, p, s;
    logic signed [BW-1:0] w;
    logic signed [DW-1:0] x, y;
    e.c = '0;
    e.ovf = '0;
    e.fin_cyc = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w = be ? bias[(i*N+j)*BW +: BW] : '0;
        acc = longint'(w);
        if (i < m && j < n) begin
          for (int kk = 0; kk < k; kk++) begin
            x = a[(i*N+kk)*DW +: DW];
            y = b[(kk*N+j)*DW +: DW];
            p = longint'(x) * longint'(y);
            s = acc + p;
            if (s > MAXV || s < MINV) e.ovf[i*N+j] = 1'b1;
            w = s[BW-1:0];
            acc = longint'(w);
          end
          e.c[(i*N+j)*BW +: BW] = acc[BW-1:0];
        end
      end
    end
    return e;
  endfunction

  function automatic logic [N*N*DW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    logic [N*N*DW-1:0] r;
    r[0*DW +: DW] = 16'(e0);
    r[1*DW +: DW] = 16'(e1);
    r[2*DW +: DW] = 16'(e2);
    r[3*DW +: DW] = 16'(e3);
    return r;
  endfunction

  // Issue one request; valid ones that are expected to finish go to the scoreboard.
  task automatic issue(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b,
                       input logic [N*N*BW-1:0] bias, input logic be,
                       input int m, input int k, input int n, input bit expect_done);
    exp_t e;
    bit ok;
    ok = (m >= 1 && m <= N && k >= 1 && k <= N && n >= 1 && n <= N);
    @(negedge clk);
    a_mat = a; b_mat = b; bias_mat = bias; bias_en = be;
    dim_m = 2'(m); dim_k = 2'(k); dim_n = 2'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_mat = {$urandom, $urandom};
    b_mat = {$urandom, $urandom};
    bias_mat = {$urandom, $urandom, $urandom, $urandom};
    bias_en = 1'($urandom);
    if (ok) begin
      chk_bit("busy_after_accept", busy, 1'b1);
      chk_bit("no_dim_err_on_accept", dim_err, 1'b0);
      if (expect_done) begin
        e = model(a, b, bias, be, m, k, n);
        e.fin_cyc = cyc + 3*N - 2;
        exp_q.push_back(e);
        last_c = e.c;
      end
    end else begin
      chk_bit("dim_err_pulse", dim_err, 1'b1);
      chk_bit("busy_on_reject", busy, 1'b0);
      @(negedge clk);
      chk_bit("dim_err_one_cycle", dim_err, 1'b0);
      chk_bit("busy_after_reject", busy, 1'b0);
      chk_vec("c_mat_held_on_reject", c_mat, last_c);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: on each finish pulse pop the oldest expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && finsh_calc === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_finish: finsh_calc high at cyc %0d, expected none", cyc);
        end else begin
          e = exp_q[0];
          chk_int("finish_latency", cyc, e.fin_cyc);
          chk_bit("busy_low_in_done", busy, 1'b0);
          @(negedge clk);
          chk_bit("finish_one_cycle", finsh_calc, 1'b0);
          chk_vec("c_mat", c_mat, e.c);
`ifdef MATMUL_OVF_DETECT_EN
          chk_int("ovf_flags", int'(ovf_flags), int'(e.ovf));
`endif
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*N*DW-1:0] ta, tb, ra, rb;
    logic [N*N*BW-1:0] ones, rbias;
    int m, k, n;

    ta = pack4(1, 2, 3, 4);
    tb = pack4(5, 6, 7, 8);
    ones = {32'd1, 32'd1, 32'd1, 32'd1};

    // Reset state
    repeat (3) @(negedge clk);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_finsh", finsh_calc, 1'b0);
    chk_bit("reset_dim_err", dim_err, 1'b0);
    chk_vec("reset_c_mat", c_mat, '0);
    reset = 1'b0;
    @(negedge clk);

    // Basic product with busy/finish timeline
    issue(ta, tb, '0, 1'b0, 2, 2, 2, 1'b1);
    chk_bit("no_early_finish_c1", finsh_calc, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk_bit("busy_compute", busy, 1'b1);
      chk_bit("no_early_finish", finsh_calc, 1'b0);
    end
    drain();
    chk_vec("c_mat_basic_const", c_mat, {32'd50, 32'd43, 32'd22, 32'd19});

    // Bias of ones
    issue(ta, tb, ones, 1'b1, 2, 2, 2, 1'b1);
    drain();
    chk_vec("c_mat_bias_const", c_mat, {32'd51, 32'd44, 32'd23, 32'd20});

    // Negative operands
    issue(pack4(-1, 0, 0, -1), pack4(3, 4, 5, 6), '0, 1'b0, 2, 2, 2, 1'b1);
    drain();
    chk_vec("c_mat_neg_const", c_mat,
            {32'hFFFFFFFA, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'hFFFFFFFD});

    // Partial dims m=1 k=2 n=1
    issue(ta, tb, ones, 1'b0, 1, 2, 1, 1'b1);
    drain();
    chk_vec("c_mat_partial_const", c_mat, {96'd0, 32'd19});

    // dim_k = 0 rejected, and dim > N rejected
    issue(ta, tb, '0, 1'b0, 2, 0, 2, 1'b1);
    issue(ta, tb, '0, 1'b0, 3, 2, 1, 1'b1);

    // Second start while busy is ignored
    issue(ta, tb, '0, 1'b0, 2, 2, 2, 1'b1);
    @(negedge clk);
    a_mat = pack4(9, 9, 9, 9); b_mat = pack4(9, 9, 9, 9);
    dim_m = 2'd2; dim_k = 2'd2; dim_n = 2'd2; bias_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_bit("busy_during_ignored_start", busy, 1'b1);
    drain();
    repeat (6) @(negedge clk);
    chk_vec("c_mat_after_ignored_start", c_mat, {32'd50, 32'd43, 32'd22, 32'd19});

    // Reset at cycle 3 aborts the job
    issue(ta, tb, '0, 1'b0, 2, 2, 2, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_finsh", finsh_calc, 1'b0);
    chk_vec("abort_c_mat", c_mat, '0);
    last_c = '0;
    repeat (8) @(negedge clk);
    chk_bit("abort_stays_idle", busy, 1'b0);

    // Most-negative operands: wraps to 0x80000000
    issue({4{16'h8000}}, {4{16'h8000}}, '0, 1'b0, 2, 2, 2, 1'b1);
    drain();
    chk_vec("c_mat_wrap_const", c_mat, {4{32'h80000000}});

    // Randomized requests
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        m = $urandom_range(0, 3); k = $urandom_range(0, 3); n = $urandom_range(0, 3);
      end else begin
        m = $urandom_range(1, N); k = $urandom_range(1, N); n = $urandom_range(1, N);
      end
      for (int e = 0; e < N*N; e++) begin
        if (it % 2 == 0) begin
          ra[e*DW +: DW] = 16'($urandom_range(0, 15) - 8);
          rb[e*DW +: DW] = 16'($urandom_range(0, 15) - 8);
        end else begin
          ra[e*DW +: DW] = 16'($urandom);
          rb[e*DW +: DW] = 16'($urandom);
        end
        rbias[e*BW +: BW] = $urandom;
      end
      issue(ra, rb, rbias, 1'($urandom), m, k, n, 1'b1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
